// File: rtl/pipeline_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// pipeline_hazard_ctrl : stall/flush controller for the five-stage pipeline
// Revision: 1.0 - initial release
// ============================================================================
module pipeline_hazard_ctrl #(
  parameter int CNT_W = 32,
  parameter int REG_W = 5
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             ihit,
  input  logic             dhit,
  input  logic [REG_W-1:0] ifid_rs,
  input  logic [REG_W-1:0] ifid_rt,
  input  logic             ifid_uses_rt,
  input  logic             idex_MemRead,
  input  logic [REG_W-1:0] idex_wsel,
  input  logic             exmem_MemRead,
  input  logic             exmem_MemWrite,
  input  logic             ex_redirect,
  input  logic             exmem_halt,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             idex_en,
  output logic             exmem_en,
  output logic             memwb_en,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             dmem_req_en,
  output logic             halted,
  output logic [CNT_W-1:0] stall_cycles
);

  typedef enum logic [0:0] {RUN = 1'b0, HALT = 1'b1} state_t;

  state_t           state_q, state_d;
  logic             ifetch_done_q, ifetch_done_d;
  logic             dacc_done_q, dacc_done_d;
  logic             halted_q, halted_d;
  logic [CNT_W-1:0] stall_cycles_q, stall_cycles_d;

  logic w_run, w_live, w_dreq, w_adv, w_lu;

  always_comb begin
    w_run  = (state_q == RUN);
    w_live = w_run & ~RST;
    w_dreq = exmem_MemRead | exmem_MemWrite;
    w_adv  = w_run & (ihit | ifetch_done_q) & (~w_dreq | dhit | dacc_done_q);
    w_lu   = idex_MemRead & (idex_wsel != '0) &
             ((idex_wsel == ifid_rs) | (ifid_uses_rt & (idex_wsel == ifid_rt)));
  end

  always_comb begin
    pc_en      = 1'b0;
    ifid_en    = 1'b0;
    idex_en    = 1'b0;
    exmem_en   = 1'b0;
    memwb_en   = 1'b0;
    ifid_flush = 1'b0;
    idex_flush = 1'b0;
    if (w_live && w_adv) begin
      pc_en    = 1'b1;
      ifid_en  = 1'b1;
      idex_en  = 1'b1;
      exmem_en = 1'b1;
      memwb_en = 1'b1;
      // A redirect squashes the decode instruction, so its load-use stall is moot
      if (ex_redirect) begin
        ifid_flush = 1'b1;
        idex_flush = 1'b1;
      end else if (w_lu) begin
        pc_en      = 1'b0;
        ifid_en    = 1'b0;
        idex_flush = 1'b1;
      end
    end
    dmem_req_en  = w_live & w_dreq & ~dacc_done_q;
    halted       = halted_q;
    stall_cycles = stall_cycles_q;
  end

  always_comb begin
    state_d        = state_q;
    ifetch_done_d  = ifetch_done_q;
    dacc_done_d    = dacc_done_q;
    halted_d       = halted_q;
    stall_cycles_d = stall_cycles_q;
    if (w_run) begin
      if (w_adv) begin
        ifetch_done_d = 1'b0;
        dacc_done_d   = 1'b0;
        if (exmem_halt) begin
          state_d  = HALT;
          halted_d = 1'b1;
        end
      end else begin
        // Remember completed accesses so they are not replayed while held
        ifetch_done_d = ifetch_done_q | ihit;
        dacc_done_d   = dacc_done_q | (dhit & w_dreq);
        if (~&stall_cycles_q)
          stall_cycles_d = stall_cycles_q + {{(CNT_W-1){1'b0}}, 1'b1};
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q        <= RUN;
      ifetch_done_q  <= 1'b0;
      dacc_done_q    <= 1'b0;
      halted_q       <= 1'b0;
      stall_cycles_q <= '0;
    end else begin
      state_q        <= state_d;
      ifetch_done_q  <= ifetch_done_d;
      dacc_done_q    <= dacc_done_d;
      halted_q       <= halted_d;
      stall_cycles_q <= stall_cycles_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_pipeline_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// tb_pipeline_hazard_ctrl : directed scoreboard bench for pipeline_hazard_ctrl
// Revision: 1.0 - initial release
// ============================================================================
module tb_pipeline_hazard_ctrl;

  localparam int CNT_W = 3;
  localparam int REG_W = 5;

  // {pc,ifid,idex,exmem,memwb, ifid_fl,idex_fl, dmem_req_en, halted}
  localparam logic [8:0] C_IDLE = 9'b00000_00_0_0;
  localparam logic [8:0] C_ADV  = 9'b11111_00_0_0;
  localparam logic [8:0] C_ADVD = 9'b11111_00_1_0;
  localparam logic [8:0] C_LU   = 9'b00111_01_0_0;
  localparam logic [8:0] C_RED  = 9'b11111_11_0_0;
  localparam logic [8:0] C_WAIT = 9'b00000_00_1_0;
  localparam logic [8:0] C_HLT  = 9'b00000_00_0_1;

  typedef struct packed {
    logic [8:0]       ctrl;
    logic [CNT_W-1:0] cnt;
    int               tag;
  } exp_t;

  logic             CLK = 1'b0;
  logic             RST;
  logic             ihit, dhit, ifid_uses_rt, idex_MemRead;
  logic [REG_W-1:0] ifid_rs, ifid_rt, idex_wsel;
  logic             exmem_MemRead, exmem_MemWrite, ex_redirect, exmem_halt;
  logic             pc_en, ifid_en, idex_en, exmem_en, memwb_en;
  logic             ifid_flush, idex_flush, dmem_req_en, halted;
  logic [CNT_W-1:0] stall_cycles;

  exp_t q[$];
  int   errors = 0;
  int   checks = 0;
  int   tag    = 0;

  pipeline_hazard_ctrl #(.CNT_W(CNT_W), .REG_W(REG_W)) dut (
    .CLK(CLK), .RST(RST), .ihit(ihit), .dhit(dhit),
    .ifid_rs(ifid_rs), .ifid_rt(ifid_rt), .ifid_uses_rt(ifid_uses_rt),
    .idex_MemRead(idex_MemRead), .idex_wsel(idex_wsel),
    .exmem_MemRead(exmem_MemRead), .exmem_MemWrite(exmem_MemWrite),
    .ex_redirect(ex_redirect), .exmem_halt(exmem_halt),
    .pc_en(pc_en), .ifid_en(ifid_en), .idex_en(idex_en), .exmem_en(exmem_en),
    .memwb_en(memwb_en), .ifid_flush(ifid_flush), .idex_flush(idex_flush),
    .dmem_req_en(dmem_req_en), .halted(halted), .stall_cycles(stall_cycles)
  );

  always #5 CLK = ~CLK;

  // Monitor: outputs are valid every cycle, so one expectation is consumed per cycle
  always @(negedge CLK) begin
    if (q.size() > 0) begin
      exp_t e;
      logic [8:0] act;
      e   = q.pop_front();
      act = {pc_en, ifid_en, idex_en, exmem_en, memwb_en,
             ifid_flush, idex_flush, dmem_req_en, halted};
      checks++;
      if (act !== e.ctrl) begin
        errors++;
        $display("FAIL ctrl step %0d: got %b expected %b", e.tag, act, e.ctrl);
      end
      checks++;
      if (stall_cycles !== e.cnt) begin
        errors++;
        $display("FAIL stall_cycles step %0d: got %0d expected %0d", e.tag, stall_cycles, e.cnt);
      end
    end
  end

  task automatic clr();
    ihit = 1'b0; dhit = 1'b0; ifid_rs = '0; ifid_rt = '0; ifid_uses_rt = 1'b0;
    idex_MemRead = 1'b0; idex_wsel = '0; exmem_MemRead = 1'b0;
    exmem_MemWrite = 1'b0; ex_redirect = 1'b0; exmem_halt = 1'b0;
  endtask

  task automatic cyc(input logic [8:0] c, input logic [CNT_W-1:0] n);
    exp_t e;
    e.ctrl = c; e.cnt = n; e.tag = tag;
    tag++;
    q.push_back(e);
    @(posedge CLK); #1;
  endtask

  initial begin
    RST = 1'b1;
    clr();
    ihit = 1'b1;
    @(posedge CLK); #1;
    cyc(C_IDLE, 3'd0);                                   // reset state, controls forced off

    // Plain ALU stream
    RST = 1'b0;
    ifid_rs = 5'd1; ifid_rt = 5'd2; cyc(C_ADV, 3'd0);
    ifid_rs = 5'd4; idex_wsel = 5'd4;      cyc(C_ADV, 3'd0);   // not a load
    ifid_rs = 5'd7; ifid_uses_rt = 1'b1;   cyc(C_ADV, 3'd0);

    // Load-use on rs, then bubble moves on
    clr(); ihit = 1'b1;
    idex_MemRead = 1'b1; idex_wsel = 5'd3; ifid_rs = 5'd3; cyc(C_LU, 3'd0);
    idex_MemRead = 1'b0;                                   cyc(C_ADV, 3'd0);
    idex_MemRead = 1'b1; idex_wsel = 5'd0; ifid_rs = 5'd0; cyc(C_ADV, 3'd0);
    idex_wsel = 5'd5; ifid_rs = 5'd1; ifid_rt = 5'd5; ifid_uses_rt = 1'b1; cyc(C_LU, 3'd0);
    ifid_uses_rt = 1'b0;                                   cyc(C_ADV, 3'd0);

    // Store in MEM: dhit on cycle 2, ihit on cycle 4
    clr(); exmem_MemWrite = 1'b1;
    cyc(C_WAIT, 3'd0);
    cyc(C_WAIT, 3'd1);
    dhit = 1'b1; cyc(C_WAIT, 3'd2);
    dhit = 1'b0; cyc(C_IDLE, 3'd3);
    ihit = 1'b1; cyc(C_ADV, 3'd4);
    exmem_MemWrite = 1'b0; cyc(C_ADV, 3'd4);

    // Fetch stall runs the counter into saturation
    ihit = 1'b0;
    cyc(C_IDLE, 3'd4); cyc(C_IDLE, 3'd5); cyc(C_IDLE, 3'd6);
    cyc(C_IDLE, 3'd7); cyc(C_IDLE, 3'd7);
    ihit = 1'b1; cyc(C_ADV, 3'd7);

    // ihit before dhit: fetch is remembered
    exmem_MemRead = 1'b1; cyc(C_WAIT, 3'd7);
    ihit = 1'b0; dhit = 1'b1; cyc(C_ADVD, 3'd7);
    // Simultaneous ihit/dhit sets no flag, so the next load waits afresh
    ihit = 1'b1; cyc(C_ADVD, 3'd7);
    dhit = 1'b0; cyc(C_WAIT, 3'd7);
    dhit = 1'b1; cyc(C_ADVD, 3'd7);

    // Redirect ignored while held, then wins over load-use
    clr(); ex_redirect = 1'b1; idex_MemRead = 1'b1; idex_wsel = 5'd3; ifid_rs = 5'd3;
    cyc(C_IDLE, 3'd7);
    ihit = 1'b1; cyc(C_RED, 3'd7);

    // Halt entry, then frozen until reset
    clr(); ihit = 1'b1; exmem_halt = 1'b1; cyc(C_ADV, 3'd7);
    exmem_halt = 1'b0; dhit = 1'b1; exmem_MemRead = 1'b1; cyc(C_HLT, 3'd7);
    cyc(C_HLT, 3'd7);
    RST = 1'b1; cyc(C_HLT, 3'd7);
    cyc(C_IDLE, 3'd0);
    clr(); RST = 1'b0; ihit = 1'b1; cyc(C_ADV, 3'd0);

    // Reset during a dcache wait discards dacc_done
    clr(); exmem_MemWrite = 1'b1; dhit = 1'b1; cyc(C_WAIT, 3'd0);
    RST = 1'b1; dhit = 1'b0; cyc(C_IDLE, 3'd1);
    RST = 1'b0; ihit = 1'b1; cyc(C_WAIT, 3'd0);
    dhit = 1'b1; cyc(C_ADVD, 3'd1);
    clr(); ihit = 1'b1; cyc(C_ADV, 3'd1);

    for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge CLK);
    if (q.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d expectations left, expected 0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/pipeline_hazard_ctrl.md
# pipeline_hazard_ctrl

Stall/flush controller for the five-stage pipeline. It consumes hazard-relevant fields from the IF/ID, ID/EX and EX/MEM latches plus the cache hit signals, and drives the enable and flush inputs of every pipeline latch and the PC. It also tracks whether the instruction fetch or data access is already complete while the pipe is held, so that no memory access is replayed. It latches processor halt and keeps a saturating stall-cycle count.

## Interface
Parameters:
- CNT_W, 32, width of the stall-cycle counter
- REG_W, 5, register-index width

Ports:
- CLK  in  1  system clock
- RST  in  1  reset; one clock CLK, reset RST is synchronous and active-high
- ihit  in  1  icache returns the fetched instruction this cycle
- dhit  in  1  dcache completes the data access this cycle
- ifid_rs, ifid_rt  in  REG_W  source registers of the instruction in decode
- ifid_uses_rt  in  1  decode instruction reads rt
- idex_MemRead  in  1  EX-stage instruction is a load
- idex_wsel  in  REG_W  EX-stage destination register
- exmem_MemRead, exmem_MemWrite  in  1  MEM-stage data access requested
- ex_redirect  in  1  branch taken, or j/jal/jr, resolved in EX
- exmem_halt  in  1  halt instruction in MEM
- pc_en, ifid_en, idex_en, exmem_en, memwb_en  out  1  latch/PC load enables
- ifid_flush, idex_flush  out  1  insert bubble on enable
- dmem_req_en  out  1  gate for dREN/dWEN to the dcache
- halted  out  1  sticky halt indicator
- stall_cycles  out  CNT_W  cycles with adv=0 outside HALT

## Operation
- State: RUN, HALT. Flags: ifetch_done and dacc_done.
- dreq = exmem_MemRead | exmem_MemWrite.
- adv = RUN & (ihit | ifetch_done) & (~dreq | dhit | dacc_done).
- dmem_req_en = RUN & dreq & ~dacc_done.
- Load-use hazard: lu = idex_MemRead & idex_wsel != 0 & (idex_wsel == ifid_rs | (ifid_uses_rt & idex_wsel == ifid_rt)).
- adv=0: all enables 0 and all flushes 0.
- adv=1 with ex_redirect: all enables 1, ifid_flush=1, idex_flush=1. Redirect has priority over lu.
- adv=1 with lu and no redirect: pc_en=0, ifid_en=0, idex_en=1, idex_flush=1, exmem_en=1, memwb_en=1.
- adv=1 otherwise: all enables 1, no flushes.
- ifetch_done: set at the edge when ihit=1 and adv=0. Cleared at the edge when adv=1.
- dacc_done: set at the edge when dhit=1, dreq=1 and adv=0. Cleared at the edge when adv=1.
- HALT entry: RUN→HALT at the edge when adv=1 and exmem_halt=1. memwb_en=1 in that cycle so the halt reaches WB.
- In HALT: all enables, flushes and dmem_req_en are 0, and halted=1. HALT is left only by reset.
- stall_cycles: increments in every RUN cycle with adv=0 and saturates at all-ones. It holds in HALT.

## Timing
- All latch controls are combinational from the inputs and the registered state, and are valid in the same cycle. The latches sample them at the next CLK edge.
- Registered items: state, ifetch_done, dacc_done, halted, stall_cycles. Each changes one edge after its condition.
- halted rises the cycle after the entry edge.
- Reset: RST sampled high at an edge sets state=RUN, both flags 0, halted=0, stall_cycles=0.
- While RST=1, all enables, flushes and dmem_req_en are forced to 0.
- Reset mid-stall discards both flags. The access is reissued after reset.
- Simultaneous ihit and dhit with dreq: adv=1 in that cycle and no flag is set.
- dhit arriving before ihit: dacc_done is set and dmem_req_en drops the next cycle. The pipe advances on ihit without waiting for a second dhit.
- idex_wsel == 0 never causes a load-use stall.
- ex_redirect with adv=0 has no effect until the cycle that advances.

## Test plan
- Plain ALU stream with ihit=1 and no dreq: all enables 1 every cycle, no flushes, stall_cycles stays 0.
- Load r3 in EX, decode reads rs=r3, ihit=1: pc_en=0, ifid_en=0, idex_flush=1 for exactly one cycle. With idex_wsel=0 instead, there is no stall.
- Store in MEM, dhit on cycle 2, ihit on cycle 4:
  - dmem_req_en=1 on cycles 0–2, 0 on cycle 3.
  - adv=1 only on cycle 4.
  - stall_cycles=4.
- ex_redirect=1 together with a load-use hazard and adv=1: all enables 1, ifid_flush=1, idex_flush=1.
- exmem_halt=1 with adv=1:
  - memwb_en=1 that cycle.
  - Next cycle halted=1 and all enables 0.
  - Enables stay 0 despite ihit/dhit until RST=1, after which halted=0.
- Counter at all-ones with a continuing stall: stall_cycles holds all-ones. RST asserted during a dcache wait: flags clear and dmem_req_en=0 while RST=1.
